fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions for the instruction fetch stage.
// Holds the reset fetch address, the NOP word and the fetch FSM encoding.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic [0:0] {
    StReq   = 1'b0,
    StValid = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues imem requests and holds one fetched word
// for the IF/ID register, with delay-slot style redirect handling.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr_0,
  output logic [31:0] PC_0,
  output logic        if_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc0_q, pc0_d;
  logic [31:0]  buf_q, buf_d;
  logic         pend_q, pend_d;
  logic [31:0]  tgt_q, tgt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StReq;
      pc_q    <= RESET_PC;
      pc0_q   <= RESET_PC;
      buf_q   <= NOP_WORD;
      pend_q  <= 1'b0;
      tgt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc0_q   <= pc0_d;
      buf_q   <= buf_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
    end
  end

  // In REQ the address is locked to pc until acked; in VALID a redirect
  // steers the request issued this very cycle.
  always_comb begin
    imem_req  = (state_q == StReq) || ((state_q == StValid) && !stall);
    imem_addr = pc_q;
    if ((state_q == StValid) && redirect) begin
      imem_addr = redirect_pc;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc0_d   = pc0_q;
    buf_d   = buf_q;
    pend_d  = pend_q;
    tgt_d   = tgt_q;

    case (state_q)
      StReq: begin
        if (imem_ack) begin
          buf_d   = imem_rdata;
          pc0_d   = pc_q;
          pend_d  = 1'b0;
          state_d = StValid;
          if (redirect) begin
            pc_d = redirect_pc;
          end else if (pend_q) begin
            pc_d = tgt_q;
          end else begin
            pc_d = pc_q + PC_STEP;
          end
        end else if (redirect) begin
          // Remember the latest target; the in-flight word is still delivered.
          pend_d = 1'b1;
          tgt_d  = redirect_pc;
        end
      end
      StValid: begin
        if (stall) begin
          if (redirect) begin
            pc_d = redirect_pc;
          end
        end else if (imem_ack) begin
          buf_d = imem_rdata;
          pc0_d = imem_addr;
          pc_d  = imem_addr + PC_STEP;
        end else begin
          pc_d    = imem_addr;
          state_d = StReq;
        end
      end
      default: begin
        state_d = StReq;
      end
    endcase
  end

  assign if_valid = (state_q == StValid);
  assign Instr_0  = if_valid ? buf_q : NOP_WORD;
  assign PC_0     = pc0_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stall/redirect/ack traffic, checked every cycle against a transaction model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instr_0;
  logic [31:0] PC_0;
  logic        if_valid;

  int n_cmp;
  int n_err;

  // Transaction model: a fetch is either locked in flight or not yet issued.
  logic        m_have;
  logic        m_inflight;
  logic [31:0] m_locked;
  logic [31:0] m_follow;
  logic [31:0] m_pc0;

  fetch_unit #(
    .RESET_PC(RST_PC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .Instr_0    (Instr_0),
    .PC_0       (PC_0),
    .if_valid   (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_have     = 1'b0;
    m_inflight = 1'b1;
    m_locked   = RST_PC;
    m_follow   = RST_PC + 32'd4;
    m_pc0      = RST_PC;
  endtask

  task automatic check_outputs();
    logic        exp_req;
    logic [31:0] exp_addr;
    exp_req  = m_inflight || (m_have && !stall);
    exp_addr = m_inflight ? m_locked : (redirect ? redirect_pc : m_follow);
    check_eq("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) check_eq("imem_addr", imem_addr, exp_addr);
    check_eq("if_valid", {31'b0, if_valid}, {31'b0, m_have});
    check_eq("PC_0", PC_0, m_pc0);
    check_eq("Instr_0", Instr_0, m_have ? mem_word(m_pc0) : 32'h0);
  endtask

  task automatic model_update();
    logic [31:0] a;
    if (m_inflight) begin
      if (imem_ack) begin
        m_pc0      = m_locked;
        m_have     = 1'b1;
        m_inflight = 1'b0;
      end
      if (redirect) m_follow = redirect_pc;
    end else if (m_have) begin
      if (stall) begin
        if (redirect) m_follow = redirect_pc;
      end else begin
        a        = redirect ? redirect_pc : m_follow;
        m_follow = a + 32'd4;
        if (imem_ack) begin
          m_pc0 = a;
        end else begin
          m_have     = 1'b0;
          m_inflight = 1'b1;
          m_locked   = a;
        end
      end
    end
  endtask

  task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic ak);
    @(negedge clk);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ack    = ak;
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Asserts reset between edges and checks the outputs react without a clock.
  task automatic do_reset();
    @(negedge clk);
    stall    = 1'b0;
    redirect = 1'b0;
    imem_ack = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_eq("rst_if_valid", {31'b0, if_valid}, 32'h0);
    check_eq("rst_Instr_0", Instr_0, 32'h0);
    check_eq("rst_PC_0", PC_0, RST_PC);
    check_eq("rst_req", {31'b0, imem_req}, 32'h1);
    check_eq("rst_addr", imem_addr, RST_PC);
    @(negedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    reset       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_ack    = 1'b0;
    model_reset();

    // Back-to-back fetches
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("seq0", PC_0, 32'h3000);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("seq1", PC_0, 32'h3004);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("seq2", PC_0, 32'h3008);
    check_eq("seq_valid", {31'b0, if_valid}, 32'h1);

    // Two-cycle stall holding 0x3008
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      check_eq("stall_pc", PC_0, 32'h3008);
      check_eq("stall_req", {31'b0, imem_req}, 32'h0);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("post_stall", PC_0, 32'h300C);

    // Ack held off on 0x3010, redirect to 0x4000 while it is outstanding
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check_eq("wait_addr", imem_addr, 32'h3010);
    check_eq("wait_instr", Instr_0, 32'h0);
    step(1'b0, 1'b1, 32'h4000, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check_eq("wait_addr2", imem_addr, 32'h3010);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("slot_pc", PC_0, 32'h3010);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("redir_pc", PC_0, 32'h4000);

    // Redirect in VALID takes effect on the same cycle's request
    step(1'b0, 1'b1, 32'h5000, 1'b1);
    check_eq("redir_valid", PC_0, 32'h5000);

    // Address wraparound
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    check_eq("wrap_top", PC_0, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("wrap_zero", PC_0, 32'h0);

    // Reset while a fetch is pending, then a late ack
    step(1'b0, 1'b0, 32'h0, 1'b0);
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("late_ack", PC_0, RST_PC);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] rpc;
      if ((i % 700) == 699) begin
        do_reset();
      end
      case ($urandom_range(0, 3))
        0:       rpc = 32'hFFFF_FFF8;
        1:       rpc = $urandom;
        default: rpc = $urandom & 32'hFFFF_FFFC;
      endcase
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), rpc,
           ($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
